// File: rtl/sequence_step_controller_pkg.sv
// Shared types and constants for the LED sequence step controller.
package seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  localparam int SEQ_LEN = 8;
  localparam int IDX_W   = 3;
  localparam int CODE_W  = 3;

  typedef logic [SEQ_LEN-1:0][CODE_W-1:0] table_t;

  // Entry 0 sits in the low slice: 4,1,6,5,2,3,7,0.
  localparam table_t DEFAULT_TABLE = {3'd0, 3'd7, 3'd3, 3'd2, 3'd5, 3'd6, 3'd1, 3'd4};
endpackage

// File: rtl/sequence_step_controller_if.sv
// Control, table-write and LED-status signals between the board side and the sequencer.
interface sequence_step_controller_if #(parameter int DIV_W = 8) ();
  import seq_ctrl_pkg::*;

  logic              start;
  logic              stop;
  logic              pause;
  logic              step;
  logic [DIV_W-1:0]  div;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [IDX_W-1:0]  cfg_addr;
  logic [CODE_W-1:0] cfg_data;
  logic [CODE_W-1:0] led;
  logic [IDX_W-1:0]  idx;
  logic              busy;
  logic              wrap;

  modport master (
    output start, stop, pause, step, div, cfg_valid, cfg_addr, cfg_data,
    input  cfg_ready, led, idx, busy, wrap
  );

  modport slave (
    input  start, stop, pause, step, div, cfg_valid, cfg_addr, cfg_data,
    output cfg_ready, led, idx, busy, wrap
  );
endinterface

// File: rtl/sequence_step_controller_prescaler.sv
// Step-rate prescaler: counts 0..div while enabled and ticks on the last count.
module step_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] count_q;

  // >= rather than == so a live div drop below the count ticks at once.
  assign tick = en && (count_q >= div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= tick ? '0 : count_q + DIV_W'(1);
    end
  end
endmodule

// File: rtl/sequence_step_controller.sv
// Programmable LED sequencer: table, run/pause/step/stop FSM, idx/led/wrap outputs.
//   state  | meaning
//   IDLE   | led=0, idx=0, table writable
//   RUN    | advancing on prescaler ticks
//   PAUSED | holding; each step cycle advances one entry
//   DONE   | single pass finished, holding table[7]
module sequence_step_controller
  import seq_ctrl_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter bit LOOP  = 1'b1
) (
  input logic                        clk,
  input logic                        reset_n,
  sequence_step_controller_if.slave  bus
);
  state_t            state_q;
  table_t            table_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_nxt;
  logic [CODE_W-1:0] led_q;
  logic              busy_q;
  logic              wrap_q;
  logic              tick;
  logic              adv;
  logic              last;
  logic              go_run;
  logic              pre_en;
  logic              pre_clr;
  logic              cfg_we;

  assign idx_nxt = idx_q + IDX_W'(1);
  assign last    = (idx_q == IDX_W'(SEQ_LEN - 1)) && !LOOP;
  assign go_run  = bus.start && !bus.stop && ((state_q == IDLE) || (state_q == DONE));
  assign pre_en  = (state_q == RUN) && !bus.pause;
  assign adv     = !bus.stop && (tick || ((state_q == PAUSED) && bus.pause && bus.step));
  assign pre_clr = bus.stop || go_run || (adv && last);
  assign cfg_we  = bus.cfg_valid && bus.cfg_ready;

  step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pre_en),
    .clr     (pre_clr),
    .div     (bus.div),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      table_q <= DEFAULT_TABLE;
      idx_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (cfg_we) table_q[bus.cfg_addr] <= bus.cfg_data;

      if (bus.stop) begin
        state_q <= IDLE;
        idx_q   <= '0;
        led_q   <= '0;
        busy_q  <= 1'b0;
      end else if (go_run) begin
        state_q <= RUN;
        idx_q   <= '0;
        led_q   <= table_q[0];
        busy_q  <= 1'b1;
      end else begin
        if ((state_q == RUN) && bus.pause) state_q <= PAUSED;
        else if ((state_q == PAUSED) && !bus.pause) state_q <= RUN;

        if (adv) begin
          wrap_q <= (idx_q == IDX_W'(SEQ_LEN - 1));
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_nxt;
            led_q <= table_q[idx_nxt];
          end
        end
      end
    end
  end

  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.led       = led_q;
  assign bus.idx       = idx_q;
  assign bus.busy      = busy_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_sequence_step_controller.sv
// Drives a looping and a single-pass sequencer with shared stimulus and checks both against a behavioural model.
module tb_sequence_step_controller;
  localparam int DIV_W = 8;
  localparam int MI = 0, MR = 1, MP = 2, MD = 3;
  localparam int DEF[8] = '{4, 1, 6, 5, 2, 3, 7, 0};
  localparam int SEQ[9] = '{4, 1, 6, 5, 2, 3, 7, 0, 4};
  localparam int STEPS[3] = '{5, 2, 3};

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start, stop, pause, step, cfg_valid;
  logic [DIV_W-1:0] div;
  logic [2:0] cfg_addr, cfg_data;

  int checks = 0;
  int errors = 0;
  int wraps;

  int m_mode[2], m_pos[2], m_cnt[2], m_led[2], m_wrap[2];
  int m_tbl[2][8];

  always #5 clk = ~clk;

  sequence_step_controller_if #(.DIV_W(DIV_W)) bus0 ();
  sequence_step_controller_if #(.DIV_W(DIV_W)) bus1 ();

  assign bus0.start = start;      assign bus1.start = start;
  assign bus0.stop = stop;        assign bus1.stop = stop;
  assign bus0.pause = pause;      assign bus1.pause = pause;
  assign bus0.step = step;        assign bus1.step = step;
  assign bus0.div = div;          assign bus1.div = div;
  assign bus0.cfg_valid = cfg_valid; assign bus1.cfg_valid = cfg_valid;
  assign bus0.cfg_addr = cfg_addr;   assign bus1.cfg_addr = cfg_addr;
  assign bus0.cfg_data = cfg_data;   assign bus1.cfg_data = cfg_data;

  sequence_step_controller #(.DIV_W(DIV_W), .LOOP(1'b1)) u_dut_loop (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  sequence_step_controller #(.DIV_W(DIV_W), .LOOP(1'b0)) u_dut_once (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = MI; m_pos[k] = 0; m_cnt[k] = 0; m_led[k] = 0; m_wrap[k] = 0;
      for (int j = 0; j < 8; j++) m_tbl[k][j] = DEF[j];
    end
  endtask

  task automatic model_advance(input int k);
    if (m_pos[k] == 7 && k == 1) begin
      m_mode[k] = MD;
      m_cnt[k]  = 0;
      m_wrap[k] = 1;
    end else begin
      m_wrap[k] = (m_pos[k] == 7) ? 1 : 0;
      m_pos[k]  = (m_pos[k] + 1) % 8;
      m_led[k]  = m_tbl[k][m_pos[k]];
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs presented to it.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit wr;
      wr = cfg_valid && (m_mode[k] == MI);
      m_wrap[k] = 0;
      if (stop) begin
        m_mode[k] = MI; m_pos[k] = 0; m_led[k] = 0; m_cnt[k] = 0;
      end else if (start && (m_mode[k] == MI || m_mode[k] == MD)) begin
        m_mode[k] = MR; m_pos[k] = 0; m_led[k] = m_tbl[k][0]; m_cnt[k] = 0;
      end else if (m_mode[k] == MR) begin
        if (pause) m_mode[k] = MP;
        else if (m_cnt[k] >= int'(div)) begin
          m_cnt[k] = 0;
          model_advance(k);
        end else m_cnt[k]++;
      end else if (m_mode[k] == MP) begin
        if (!pause) m_mode[k] = MR;
        else if (step) model_advance(k);
      end
      if (wr) m_tbl[k][cfg_addr] = int'(cfg_data);
    end
  endtask

  task automatic check_all();
    chk("led_loop",  32'(bus0.led),       32'(m_led[0]));
    chk("idx_loop",  32'(bus0.idx),       32'(m_pos[0]));
    chk("busy_loop", 32'(bus0.busy),      32'(m_mode[0] == MR || m_mode[0] == MP));
    chk("wrap_loop", 32'(bus0.wrap),      32'(m_wrap[0]));
    chk("rdy_loop",  32'(bus0.cfg_ready), 32'(m_mode[0] == MI));
    chk("led_once",  32'(bus1.led),       32'(m_led[1]));
    chk("idx_once",  32'(bus1.idx),       32'(m_pos[1]));
    chk("busy_once", 32'(bus1.busy),      32'(m_mode[1] == MR || m_mode[1] == MP));
    chk("wrap_once", 32'(bus1.wrap),      32'(m_wrap[1]));
    chk("rdy_once",  32'(bus1.cfg_ready), 32'(m_mode[1] == MI));
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    start = 0; stop = 0; pause = 0; step = 0; cfg_valid = 0;
    div = '0; cfg_addr = '0; cfg_data = '0;
    model_reset();

    #1 reset_n = 1'b0;
    #12;
    chk("rst_led",  32'(bus0.led), 0);
    chk("rst_idx",  32'(bus0.idx), 0);
    chk("rst_busy", 32'(bus0.busy), 0);
    chk("rst_wrap", 32'(bus0.wrap), 0);
    chk("rst_rdy",  32'(bus0.cfg_ready), 1);
    @(negedge clk) reset_n = 1'b1;
    cyc();

    // Full default pass at div=0.
    div = 0; start = 1; cyc(); start = 0;
    chk("seq0", 32'(bus0.led), 32'(SEQ[0]));
    wraps = 0;
    for (int i = 1; i < 9; i++) begin
      cyc();
      chk("seq", 32'(bus0.led), 32'(SEQ[i]));
      wraps += int'(bus0.wrap);
    end
    chk("wrap_count", 32'(wraps), 1);
    chk("done_led",  32'(bus1.led), 0);
    chk("done_idx",  32'(bus1.idx), 7);
    chk("done_busy", 32'(bus1.busy), 0);
    start = 1; cyc(); start = 0;
    chk("replay_led", 32'(bus1.led), 4);
    cyc();
    stop = 1; cyc(); stop = 0;

    // Dwell of div+1 cycles, then a pause mid-dwell.
    div = 3; start = 1; cyc(); start = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("dwell_hold", 32'(bus0.led), 4);
    end
    cyc();
    chk("dwell_next", 32'(bus0.led), 1);
    repeat (5) cyc();
    pause = 1; repeat (10) cyc();
    pause = 0; repeat (16) cyc();
    stop = 1; cyc(); stop = 0;

    // Single-stepping from idx 2.
    div = 0; start = 1; cyc(); start = 0;
    cyc(); cyc();
    pause = 1; cyc();
    chk("paused_idx", 32'(bus0.idx), 2);
    chk("paused_led", 32'(bus0.led), 6);
    step = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("step_led", 32'(bus0.led), 32'(STEPS[i]));
    end
    step = 0;
    chk("step_idx", 32'(bus0.idx), 5);
    pause = 0; stop = 1; cyc(); stop = 0;

    // Table write in IDLE, blocked write while running.
    cfg_valid = 1; cfg_addr = 0; cfg_data = 7;
    chk("rdy_idle", 32'(bus0.cfg_ready), 1);
    cyc(); cfg_valid = 0;
    start = 1; cyc(); start = 0;
    chk("wr_first", 32'(bus0.led), 7);
    cfg_valid = 1; cfg_addr = 1; cfg_data = 0;
    chk("rdy_run", 32'(bus0.cfg_ready), 0);
    cyc(); cfg_valid = 0;
    chk("wr_blocked", 32'(bus0.led), 1);
    stop = 1; cyc(); stop = 0;

    // Reset in the middle of a run restores the default table.
    start = 1; cyc(); start = 0;
    repeat (5) cyc();
    chk("pre_rst_idx", 32'(bus0.idx), 5);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_led",  32'(bus0.led), 0);
    chk("midrst_busy", 32'(bus0.busy), 0);
    chk("midrst_idx",  32'(bus0.idx), 0);
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    start = 1; cyc(); start = 0;
    chk("default_t0", 32'(bus0.led), 4);
    cyc();
    chk("default_t1", 32'(bus0.led), 1);
    stop = 1; cyc(); stop = 0;

    // Randomized control traffic against the model.
    for (int i = 0; i < 500; i++) begin
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) pause = !pause;
      step  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) div = DIV_W'($urandom_range(0, 4));
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_addr  = 3'($urandom_range(0, 7));
      cfg_data  = 3'($urandom_range(0, 7));
      cyc();
    end
    start = 0; stop = 0; pause = 0; step = 0; cfg_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
